// File: rtl/tt_spine_sel_pkg.sv
// Shared types and constants for the spine selection controller.
// Holds the FSM state encoding and select bus width.
package tt_spine_sel_pkg;

  localparam int TT_SEL_W = 10;

  typedef enum logic [1:0] {
    TT_SEL_ST_IDLE   = 2'd0,
    TT_SEL_ST_DRAIN  = 2'd1,
    TT_SEL_ST_SETTLE = 2'd2
  } tt_sel_st_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tt_sync_ff.sv
// N-stage flip-flop synchroniser for slow asynchronous pins.
// All stages clear to 0 on reset.
module tt_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_q;
  logic [STAGES-1:0] ff_d;

  always_comb begin
    ff_d = {ff_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_q <= '0;
    end else begin
      ff_q <= ff_d;
    end
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/tt_spine_sel.sv
// Spine select/enable owner: target counter plus a
// break-before-make switch sequence towards the row muxes.
module tt_spine_sel
  import tt_spine_sel_pkg::*;
#(
  parameter int ADDR_W      = TT_SEL_W,
  parameter int SYNC_STAGES = 2,
  parameter int T_DEAD      = 4,
  parameter int T_SETTLE    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ext_sel_rst,
  input  logic              ext_sel_inc,
  input  logic              ext_ena,
  output logic [ADDR_W-1:0] spine_sel,
  output logic              spine_ena,
  output logic              busy
);

  localparam int CNT_W =
    $clog2(max2(T_DEAD, T_SETTLE) + 1);
  localparam logic [CNT_W-1:0] DEAD_LAST =
    CNT_W'(T_DEAD - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST =
    CNT_W'(T_SETTLE - 1);

  logic s_rst;
  logic s_inc;
  logic s_ena;
  logic s_inc_q;
  logic inc_pulse;

  tt_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_rst (
    .clk (clk),
    .rst (rst),
    .d   (ext_sel_rst),
    .q   (s_rst)
  );

  tt_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_inc (
    .clk (clk),
    .rst (rst),
    .d   (ext_sel_inc),
    .q   (s_inc)
  );

  tt_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ena (
    .clk (clk),
    .rst (rst),
    .d   (ext_ena),
    .q   (s_ena)
  );

  assign inc_pulse = s_inc & ~s_inc_q;

  tt_sel_st_e        st_q,   st_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic [ADDR_W-1:0] tgt_q,  tgt_d;
  logic [ADDR_W-1:0] sel_q,  sel_d;
  logic              ena_q,  ena_d;
  logic              busy_q, busy_d;

  // Target tracks the pins in every state so no increment is lost.
  always_comb begin
    tgt_d = tgt_q;
    if (s_rst) begin
      tgt_d = '0;
    end else if (inc_pulse) begin
      tgt_d = tgt_q + 1'b1;
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    sel_d = sel_q;
    ena_d = ena_q;
    case (st_q)
      TT_SEL_ST_IDLE: begin
        if (tgt_q != sel_q) begin
          st_d  = TT_SEL_ST_DRAIN;
          cnt_d = '0;
          ena_d = 1'b0;
        end else begin
          ena_d = s_ena;
        end
      end
      TT_SEL_ST_DRAIN: begin
        ena_d = 1'b0;
        if (cnt_q == DEAD_LAST) begin
          sel_d = tgt_q;
          cnt_d = '0;
          st_d  = TT_SEL_ST_SETTLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TT_SEL_ST_SETTLE: begin
        ena_d = 1'b0;
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          // Enable is already low, so a late change re-arms settle only.
          if (tgt_q != sel_q) begin
            sel_d = tgt_q;
          end else begin
            st_d  = TT_SEL_ST_IDLE;
            ena_d = s_ena;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        st_d  = TT_SEL_ST_IDLE;
        cnt_d = '0;
        ena_d = 1'b0;
      end
    endcase
    busy_d = (st_d != TT_SEL_ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_inc_q <= 1'b0;
      st_q    <= TT_SEL_ST_IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      sel_q   <= '0;
      ena_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      s_inc_q <= s_inc;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      sel_q   <= sel_d;
      ena_q   <= ena_d;
      busy_q  <= busy_d;
    end
  end

  assign spine_sel = sel_q;
  assign spine_ena = ena_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_tt_spine_sel.sv
// Scoreboard bench for tt_spine_sel: pulse-count target model,
// expected select values queued, monitor checks values and timing.
module tb_tt_spine_sel;

  localparam int W  = 10;
  localparam int TD = 4;
  localparam int TS = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ext_sel_rst = 1'b0;
  logic         ext_sel_inc = 1'b0;
  logic         ext_ena = 1'b0;
  logic [W-1:0] spine_sel;
  logic         spine_ena;
  logic         busy;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  int model_tgt = 0;
  int exp_q[$];
  bit burst = 1'b0;

  tt_spine_sel dut (
    .clk         (clk),
    .rst         (rst),
    .ext_sel_rst (ext_sel_rst),
    .ext_sel_inc (ext_sel_inc),
    .ext_ena     (ext_ena),
    .spine_sel   (spine_sel),
    .spine_ena   (spine_ena),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int req);
    vecs++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  // Monitor: every select change must match the queue head and obey
  // dead/settle timing; enable must be low on both sides of it.
  logic [W-1:0] p_sel  = '0;
  logic         p_ena  = 1'b0;
  logic         p_busy = 1'b0;
  int           drain_c = 0;
  int           chg_c   = 0;
  bit           first   = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      first = 1'b0;
    end else begin
      if (busy && !p_busy) begin
        drain_c = cyc;
        first   = 1'b1;
      end
      if (spine_sel != p_sel) begin
        chk("sel_chg_ena_low", int'({p_ena, spine_ena}), 0);
        if (first) chk("dead_time", cyc - drain_c, TD);
        else       chk("settle_rearm", cyc - chg_c, TS);
        first = 1'b0;
        chg_c = cyc;
        if (exp_q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected_sel: got %0d want none",
                   spine_sel);
        end else if (!burst || int'(spine_sel) == exp_q[0]) begin
          chk("sel_value", int'(spine_sel), exp_q[0]);
          void'(exp_q.pop_front());
        end
      end
      if (!busy && p_busy) chk("settle_time", cyc - chg_c, TS);
    end
    p_sel  = spine_sel;
    p_ena  = spine_ena;
    p_busy = busy;
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int hi, input int lo);
    ext_sel_inc = 1'b1;
    cyc_wait(hi);
    ext_sel_inc = 1'b0;
    cyc_wait(lo);
  endtask

  task automatic step(input int n, input int hi, input int lo);
    model_tgt = (model_tgt + n) % 1024;
    exp_q.push_back(model_tgt);
    for (int i = 0; i < n; i++) pulse(hi, lo);
  endtask

  task automatic quiesce();
    int q = 0;
    int t = 0;
    while (q < 12 && t < 400) begin
      @(negedge clk);
      if (busy) q = 0;
      else q++;
      t++;
    end
    if (q < 12) chk("quiesce_timeout", 0, 1);
    cyc_wait(1);
  endtask

  task automatic edge_sample(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    cyc_wait(3);
    @(negedge clk);
    chk("rst_sel", int'(spine_sel), 0);
    chk("rst_ena", int'(spine_ena), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ext_ena = 1'b1;
    edge_sample(2);
    chk("ena_early", int'(spine_ena), 0);
    edge_sample(1);
    chk("ena_3cyc", int'(spine_ena), 1);

    // single increment, exact edge timing
    @(posedge clk);
    #1;
    model_tgt = 1;
    exp_q.push_back(1);
    ext_sel_inc = 1'b1;
    edge_sample(3);
    chk("pre_drain_ena", int'(spine_ena), 1);
    chk("pre_drain_busy", int'(busy), 0);
    edge_sample(1);
    chk("drain_ena", int'(spine_ena), 0);
    chk("drain_busy", int'(busy), 1);
    ext_sel_inc = 1'b0;
    edge_sample(4);
    chk("sel_after_dead", int'(spine_sel), 1);
    edge_sample(7);
    chk("settle_ena_low", int'(spine_ena), 0);
    edge_sample(1);
    chk("settle_ena_up", int'(spine_ena), 1);
    chk("settle_busy", int'(busy), 0);
    cyc_wait(1);

    // three pulses collapse into one step during drain
    step(3, 1, 1);
    quiesce();
    chk("burst_sel", int'(spine_sel), 4);
    chk("burst_ena", int'(spine_ena), 1);

    // increment landing in settle re-arms settle
    step(1, 3, 3);
    cyc_wait(3);
    step(1, 3, 3);
    quiesce();
    chk("rearm_sel", int'(spine_sel), 6);
    chk("rearm_ena", int'(spine_ena), 1);

    // run up to 1023, then wrap
    burst = 1'b1;
    step(1017, 1, 1);
    quiesce();
    burst = 1'b0;
    chk("top_sel", int'(spine_sel), 1023);
    step(1, 3, 3);
    quiesce();
    chk("wrap_sel", int'(spine_sel), 0);

    // random enable levels with slow or burst increments
    for (int it = 0; it < 10; it++) begin
      int  en;
      int  n;
      en = int'($urandom_range(0, 1));
      ext_ena = en[0];
      cyc_wait(4);
      if ($urandom_range(0, 1) == 1) begin
        step(1, 3 + int'($urandom_range(0, 3)),
             3 + int'($urandom_range(0, 3)));
      end else begin
        n = int'($urandom_range(2, 3));
        step(n, 1, 1);
      end
      quiesce();
      chk("rand_sel", int'(spine_sel), model_tgt);
      chk("rand_ena", int'(spine_ena), en);
    end

    // ext_sel_rst forces zero and blocks increments
    ext_ena = 1'b1;
    if (model_tgt != 0) begin
      model_tgt = 0;
      exp_q.push_back(0);
    end
    ext_sel_rst = 1'b1;
    quiesce();
    ext_sel_rst = 1'b0;
    cyc_wait(4);
    burst = 1'b1;
    step(5, 1, 1);
    quiesce();
    burst = 1'b0;
    chk("pre_srst_sel", int'(spine_sel), 5);
    ext_sel_rst = 1'b1;
    model_tgt = 0;
    exp_q.push_back(0);
    cyc_wait(4);
    for (int i = 0; i < 3; i++) pulse(3, 3);
    quiesce();
    chk("srst_sel", int'(spine_sel), 0);
    chk("srst_ena", int'(spine_ena), 1);
    ext_sel_rst = 1'b0;
    cyc_wait(4);

    // reset in the middle of settle
    step(1, 3, 3);
    cyc_wait(4);
    chk("mid_settle_busy", int'(busy), 1);
    chk("mid_settle_q", exp_q.size(), 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_sel", int'(spine_sel), 0);
    chk("arst_ena", int'(spine_ena), 0);
    chk("arst_busy", int'(busy), 0);
    model_tgt = 0;
    exp_q.delete();
    cyc_wait(2);
    rst = 1'b0;
    edge_sample(2);
    chk("rel_ena_early", int'(spine_ena), 0);
    edge_sample(1);
    chk("rel_ena_3cyc", int'(spine_ena), 1);
    chk("rel_sel", int'(spine_sel), 0);
    cyc_wait(2);
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
